inst_fetch_unit: RTL and testbench

Instruction fetch stage. It owns the program counter and drives the instruction ROM's byte address. It absorbs the ROM's one-cycle read latency and hands {pc, instruction} pairs to decode over a valid/ready handshake. A 2-entry buffer lets decode stall without losing a fetched word. A single redirect input serves branches, jumps and traps.

---
 rtl/inst_fetch_unit_pkg.sv | 11 +
 rtl/inst_fetch_unit_buffer.sv | 59 +++++
 rtl/inst_fetch_unit.sv | 76 +++++++
 tb/tb_inst_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

package inst_fetch_unit_pkg;
  localparam int unsigned ROM_ADDR_W       = `ROM_ADDRESS_BITWIDTH;
  localparam int unsigned INST_W_DEFAULT   = 32;
  localparam int unsigned RESET_PC_DEFAULT = 0;
  localparam int unsigned PC_STEP          = 4;
endpackage

// File: rtl/inst_fetch_unit_buffer.sv
// Two-entry {pc, instruction} FIFO with flush; head comes straight from storage registers.
module fetch_buffer
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned INST_W = INST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  logic [ADDR_W-1:0] pc_mem   [2];
  logic [INST_W-1:0] inst_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              pop_ok;

  assign pop_ok = pop & (count != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= push_pc;
        inst_mem[wr_ptr] <= push_inst;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop_ok);
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_inst  = inst_mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues ROM reads under a 2-slot credit and buffers returned words.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ROM_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       INST_W   = INST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  logic              unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // Credit: buffered + in-flight words after this cycle's pop must leave room for one more.
  always_comb begin
    rom_address = fetch_pc;
    if (redirect_valid) begin
      rom_address = {redirect_pc[ADDR_W-1:2], 2'b00};
    end
    pop       = inst_valid & inst_ready;
    push      = inflight & ~redirect_valid;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = redirect_valid | (occupancy < 3'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= rom_address;
      fetch_pc    <= rom_address + ADDR_W'(PC_STEP);
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_inst  (rom_data),
    .pop        (pop),
    .count      (count),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_inst  (inst)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: stream, stall, redirect, alignment, PC wrap and async reset.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int unsigned       AW      = ROM_ADDR_W;
  localparam logic [AW-1:0]     WRAP_PC = {AW{1'b1}} - AW'(7);

  logic          clk;
  logic          reset;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;

  logic [AW-1:0] w_rom_address;
  logic [31:0]   w_rom_data;
  logic          w_redirect_valid;
  logic [AW-1:0] w_redirect_pc;
  logic          w_inst_valid;
  logic          w_inst_ready;
  logic [31:0]   w_inst;
  logic [AW-1:0] w_inst_pc;

  int checks;
  int failures;

  inst_fetch_unit #(.ADDR_W(AW), .RESET_PC(AW'(0)), .INST_W(32)) dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  inst_fetch_unit #(.ADDR_W(AW), .RESET_PC(WRAP_PC), .INST_W(32)) dut_w (
    .clk(clk), .reset(reset), .rom_address(w_rom_address), .rom_data(w_rom_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc)
  );

  // ROM contents: a fixed, address-unique word per byte address.
  function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'd3 + 32'd1);
  endfunction

  always @(posedge clk) begin
    rom_data   <= rom_fn(rom_address);
    w_rom_data <= rom_fn(w_rom_address);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [AW-1:0] pc);
    check({tag, ".valid"}, 64'(inst_valid), 64'(v));
    if (v) begin
      check({tag, ".pc"}, 64'(inst_pc), 64'(pc));
      check({tag, ".inst"}, 64'(inst), 64'(rom_fn(pc)));
    end
  endtask

  task automatic expect_wrap(input string tag, input logic [AW-1:0] pc);
    check({tag, ".valid"}, 64'(w_inst_valid), 64'd1);
    check({tag, ".pc"}, 64'(w_inst_pc), 64'(pc));
    check({tag, ".inst"}, 64'(w_inst), 64'(rom_fn(pc)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after a posedge with reset just released: cycle 0.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_inst_ready     = 1'b1;

    // Reset state and straight-line streaming.
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    tick(); tick();
    check("rst.valid", 64'(inst_valid), 64'd0);
    check("rst.inst", 64'(inst), 64'd0);
    check("rst.pc", 64'(inst_pc), 64'd0);
    check("rst.addr", 64'(rom_address), 64'd0);
    check("rst.waddr", 64'(w_rom_address), 64'(WRAP_PC));
    reset = 1'b0;
    #1 check("s0.addr", 64'(rom_address), 64'h0); expect_out("s0", 1'b0, '0);
    tick(); check("s1.addr", 64'(rom_address), 64'h4); expect_out("s1", 1'b0, '0);
    tick(); check("s2.addr", 64'(rom_address), 64'h8); expect_out("s2", 1'b1, AW'(0));
    expect_wrap("w2", WRAP_PC);
    tick(); check("s3.addr", 64'(rom_address), 64'hc); expect_out("s3", 1'b1, AW'(4));
    expect_wrap("w3", WRAP_PC + AW'(4));
    tick(); expect_out("s4", 1'b1, AW'(8));  expect_wrap("w4", AW'(0));
    tick(); expect_out("s5", 1'b1, AW'(12)); expect_wrap("w5", AW'(4));

    // Stall for 5 cycles with (0,A) at the head.
    do_reset();
    tick();
    tick(); inst_ready = 1'b0;
    #1 expect_out("st2", 1'b1, AW'(0)); check("st2.addr", 64'(rom_address), 64'h8);
    for (int k = 3; k <= 6; k++) begin
      tick();
      expect_out("st.hold", 1'b1, AW'(0));
      check("st.addr", 64'(rom_address), 64'h8);
      check("st.count", 64'(dut.u_buf.count), 64'd2);
    end
    tick(); inst_ready = 1'b1;
    #1 expect_out("st7", 1'b1, AW'(0));
    tick(); expect_out("st8", 1'b1, AW'(4));
    tick(); expect_out("st9", 1'b1, AW'(8));
    tick(); expect_out("st10", 1'b1, AW'(12));
    tick(); expect_out("st11", 1'b1, AW'(16));

    // Redirect with a full buffer, then alignment and back-to-back redirects.
    do_reset();
    tick();
    tick(); inst_ready = 1'b0;
    tick();
    tick(); check("rd.full", 64'(dut.u_buf.count), 64'd2);
    redirect_valid = 1'b1; redirect_pc = AW'(16'h40);
    #1 check("rd.addr", 64'(rom_address), 64'h40);
    tick(); redirect_valid = 1'b0; inst_ready = 1'b1;
    #1 expect_out("rd1", 1'b0, '0);
    tick(); expect_out("rd2", 1'b1, AW'(16'h40));
    tick(); expect_out("rd3", 1'b1, AW'(16'h44));
    tick(); expect_out("rd4", 1'b1, AW'(16'h48));
    tick(); redirect_valid = 1'b1; redirect_pc = AW'(16'h43);
    #1 check("al.addr", 64'(rom_address), 64'h40);
    tick(); redirect_valid = 1'b0;
    #1 expect_out("al1", 1'b0, '0);
    tick(); expect_out("al2", 1'b1, AW'(16'h40));
    tick(); redirect_valid = 1'b1; redirect_pc = AW'(16'h100);
    tick(); redirect_pc = AW'(16'h200);
    #1 expect_out("bb1", 1'b0, '0);
    tick(); redirect_valid = 1'b0;
    #1 expect_out("bb2", 1'b0, '0);
    tick(); expect_out("bb3", 1'b1, AW'(16'h200));
    tick(); expect_out("bb4", 1'b1, AW'(16'h204));

    // Asynchronous reset with a full buffer, then restart.
    do_reset();
    tick();
    tick(); inst_ready = 1'b0;
    tick();
    tick(); check("ar.full", 64'(dut.u_buf.count), 64'd2);
    #2 reset = 1'b1;
    #1 check("ar.valid", 64'(inst_valid), 64'd0);
    check("ar.count", 64'(dut.u_buf.count), 64'd0);
    inst_ready = 1'b1;
    tick(); reset = 1'b0;
    #1 check("ar0.addr", 64'(rom_address), 64'h0); expect_out("ar0", 1'b0, '0);
    tick(); expect_out("ar1", 1'b0, '0);
    tick(); expect_out("ar2", 1'b1, AW'(0));
    tick(); expect_out("ar3", 1'b1, AW'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
